alu: RTL and testbench

//  Registered N-bit ALU between the stimulus driver and the result checker.
//  Two operands (OPA/OPB), command CMD, MODE (1=arithmetic, 0=logical).
//  Per-operand valid bits (INP_VALID); RES is N+1 bits, plus flags.
//  One result per clock-enabled cycle, one-cycle latency.

---
 rtl/alu_if.sv | 31 +++
 rtl/alu.sv | 148 ++++++++++++++
 tb/tb_alu.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand, command and result bundle between the stimulus driver and the ALU.
// The master drives operands and command. The slave, which is the ALU, returns the result and flags.
interface alu_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic [1:0]   inp_valid;
  logic         ce;
  logic         cin;
  logic         mode;
  logic [M-1:0] cmd;
  logic [N-1:0] opa;
  logic [N-1:0] opb;
  logic [N:0]   res;
  logic         cout;
  logic         oflow;
  logic         e;
  logic         g;
  logic         l;
  logic         err;

  modport master (
    output inp_valid, ce, cin, mode, cmd, opa, opb,
    input  res, cout, oflow, e, g, l, err
  );

  modport slave (
    input  inp_valid, ce, cin, mode, cmd, opa, opb,
    output res, cout, oflow, e, g, l, err
  );
endinterface

// File: rtl/alu.sv
// Registered N-bit ALU: arithmetic and logical commands with operand-valid checks.
// Every output is registered and updates on each clock-enabled edge.
module alu #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);
  localparam int SH = $clog2(N);
  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input logic [SH-1:0] s);
    logic [2*N-1:0] d;
    d = {v, v} << s;
    return d[2*N-1:N];
  endfunction

  function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input logic [SH-1:0] s);
    logic [2*N-1:0] d;
    d = {v, v} >> s;
    return d[N-1:0];
  endfunction

  logic [31:0]  op;
  logic [1:0]   need;
  logic         bad_cmd;
  logic         rot_ok;
  logic [N:0]   a_x, b_x, cin_x;
  logic [N-1:0] lres;
  logic [N:0]   res_nx;
  logic         cout_nx, oflow_nx, e_nx, g_nx, l_nx, err_nx;

  logic [N:0]   res_p0;
  logic         cout_p0, oflow_p0, e_p0, g_p0, l_p0, err_p0;

  always_comb begin
    op       = 32'(bus.cmd);
    a_x      = {1'b0, bus.opa};
    b_x      = {1'b0, bus.opb};
    cin_x    = {{N{1'b0}}, bus.cin};
    rot_ok   = (bus.opb >> SH) == '0;
    need     = 2'b11;
    bad_cmd  = 1'b0;
    lres     = '0;
    res_nx   = '0;
    cout_nx  = 1'b0;
    oflow_nx = 1'b0;
    e_nx     = 1'b0;
    g_nx     = 1'b0;
    l_nx     = 1'b0;
    err_nx   = 1'b0;

    // Operand requirement for the selected command
    if (bus.mode) begin
      case (op)
        0, 1, 2, 3, 8: need = 2'b11;
        4, 5:          need = 2'b01;
        6, 7:          need = 2'b10;
        default:       bad_cmd = 1'b1;
      endcase
    end else begin
      case (op)
        0, 1, 2, 3, 4, 5, 12, 13: need = 2'b11;
        6, 8, 9:                  need = 2'b01;
        7, 10, 11:                need = 2'b10;
        default:                  bad_cmd = 1'b1;
      endcase
    end

    if (bad_cmd || ((bus.inp_valid & need) != need)) begin
      err_nx = 1'b1;
    end else if (bus.mode) begin
      case (op)
        0: begin res_nx = a_x + b_x;         cout_nx = res_nx[N]; end
        1: begin res_nx = a_x - b_x;         oflow_nx = bus.opa < bus.opb; end
        2: begin res_nx = a_x + b_x + cin_x; cout_nx = res_nx[N]; end
        3: begin
          res_nx   = a_x - b_x - cin_x;
          oflow_nx = a_x < (b_x + cin_x);
          cout_nx  = oflow_nx;
        end
        4: res_nx = a_x + ONE;
        5: res_nx = a_x - ONE;
        6: res_nx = b_x + ONE;
        7: res_nx = b_x - ONE;
        default: begin
          e_nx = bus.opa == bus.opb;
          g_nx = bus.opa >  bus.opb;
          l_nx = bus.opa <  bus.opb;
        end
      endcase
    end else begin
      case (op)
        0:  lres = bus.opa & bus.opb;
        1:  lres = ~(bus.opa & bus.opb);
        2:  lres = bus.opa | bus.opb;
        3:  lres = ~(bus.opa | bus.opb);
        4:  lres = bus.opa ^ bus.opb;
        5:  lres = ~(bus.opa ^ bus.opb);
        6:  lres = ~bus.opa;
        7:  lres = ~bus.opb;
        8:  lres = bus.opa >> 1;
        9:  lres = bus.opa << 1;
        10: lres = bus.opb >> 1;
        11: lres = bus.opb << 1;
        12: lres = rotl(bus.opa, bus.opb[SH-1:0]);
        default: lres = rotr(bus.opa, bus.opb[SH-1:0]);
      endcase
      // Out-of-range rotate amounts report an error with a cleared result
      if ((op == 12 || op == 13) && !rot_ok) begin
        err_nx = 1'b1;
        lres   = '0;
      end
      res_nx = {1'b0, lres};
    end
  end

  // Stage p0: output register, cleared by reset, held while ce is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_p0   <= '0;
      cout_p0  <= 1'b0;
      oflow_p0 <= 1'b0;
      e_p0     <= 1'b0;
      g_p0     <= 1'b0;
      l_p0     <= 1'b0;
      err_p0   <= 1'b0;
    end else if (bus.ce) begin
      res_p0   <= res_nx;
      cout_p0  <= cout_nx;
      oflow_p0 <= oflow_nx;
      e_p0     <= e_nx;
      g_p0     <= g_nx;
      l_p0     <= l_nx;
      err_p0   <= err_nx;
    end
  end

  assign bus.res   = res_p0;
  assign bus.cout  = cout_p0;
  assign bus.oflow = oflow_p0;
  assign bus.e     = e_p0;
  assign bus.g     = g_p0;
  assign bus.l     = l_p0;
  assign bus.err   = err_p0;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases followed by random traffic.
// All stimulus is checked against an integer reference model.
module tb_alu;
  logic clk;
  logic rst;
  int   tests  = 0;
  int   failed = 0;
  logic [14:0] expv;

  alu_if #(.N(8), .M(4)) bus ();

  alu #(.N(8), .M(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result packed as {res[8:0], cout, oflow, e, g, l, err}
  function automatic logic [14:0] model(input int md, input int cmd, input int a,
                                        input int b, input int cin, input int iv);
    int r = 0;
    int need = -1;
    int s;
    logic co = 0, of = 0, fe = 0, fg = 0, fl = 0, er = 0;
    logic [31:0] rv;
    if (md != 0) begin
      if (cmd <= 3 || cmd == 8) need = 3;
      else if (cmd == 4 || cmd == 5) need = 1;
      else if (cmd == 6 || cmd == 7) need = 2;
    end else begin
      if (cmd <= 5 || cmd == 12 || cmd == 13) need = 3;
      else if (cmd == 6 || cmd == 8 || cmd == 9) need = 1;
      else if (cmd == 7 || cmd == 10 || cmd == 11) need = 2;
    end
    if (need < 0 || (iv & need) != need) begin
      er = 1;
    end else if (md != 0) begin
      case (cmd)
        0: begin r = a + b;       co = (r >= 256); end
        1: begin r = (a - b + 512) % 512;       of = (a < b); end
        2: begin r = a + b + cin; co = (r >= 256); end
        3: begin r = (a - b - cin + 512) % 512; of = (a < b + cin); co = of; end
        4: r = a + 1;
        5: r = (a + 511) % 512;
        6: r = b + 1;
        7: r = (b + 511) % 512;
        default: begin fe = (a == b); fg = (a > b); fl = (a < b); end
      endcase
    end else begin
      case (cmd)
        0: r = a & b;
        1: r = 255 - (a & b);
        2: r = a | b;
        3: r = 255 - (a | b);
        4: r = a ^ b;
        5: r = 255 - (a ^ b);
        6: r = 255 - a;
        7: r = 255 - b;
        8: r = a / 2;
        9: r = (a * 2) % 256;
        10: r = b / 2;
        11: r = (b * 2) % 256;
        default: begin
          if (b >= 8) er = 1;
          else begin
            s = b;
            if (cmd == 12) r = ((a * (1 << s)) + (a / (1 << (8 - s)))) % 256;
            else           r = ((a / (1 << s)) + (a * (1 << (8 - s)))) % 256;
          end
        end
      endcase
    end
    rv = 32'(r);
    return {rv[8:0], co, of, fe, fg, fl, er};
  endfunction

  task automatic check(input string tag);
    logic [14:0] obs;
    obs = {bus.res, bus.cout, bus.oflow, bus.e, bus.g, bus.l, bus.err};
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed res=%h cout/oflow/e/g/l/err=%b, expected res=%h cout/oflow/e/g/l/err=%b",
             tag, obs[14:6], obs[5:0], expv[14:6], expv[5:0]);
    end
  endtask

  task automatic drive(input int md, input int cmd, input int a, input int b,
                       input int cin, input int iv, input logic ce_v);
    bus.mode      = md[0];
    bus.cmd       = cmd[3:0];
    bus.opa       = a[7:0];
    bus.opb       = b[7:0];
    bus.cin       = cin[0];
    bus.inp_valid = iv[1:0];
    bus.ce        = ce_v;
  endtask

  task automatic op(input string tag, input int md, input int cmd, input int a,
                    input int b, input int cin, input int iv);
    drive(md, cmd, a, b, cin, iv, 1'b1);
    @(posedge clk);
    #1;
    expv = model(md, cmd, a, b, cin, iv);
    check(tag);
  endtask

  task automatic idle_cycle(input string tag);
    drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
          $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 3), 1'b0);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    int md, cmd, a, b, cin, iv;
    logic ce_v;
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 3, 1'b1);
    expv = '0;
    @(posedge clk);
    #1;
    check("reset_initial");
    rst = 1'b0;

    op("pre_reset_add", 1, 0, 8'h10, 8'h20, 0, 3);
    drive(1, 0, 8'h33, 8'h44, 0, 3, 1'b1);
    rst = 1'b1;
    #1;
    expv = '0;
    check("reset_async");
    @(posedge clk);
    #1;
    check("reset_held");
    rst = 1'b0;

    op("add_carry",    1, 0, 8'hFF, 8'h01, 0, 3);
    op("sub_under",    1, 1, 8'h05, 8'h0A, 0, 3);
    op("sub_cin_zero", 1, 3, 8'h05, 8'h04, 1, 3);
    op("sub_cin_brw",  1, 3, 8'h04, 8'h04, 1, 3);
    op("add_cin",      1, 2, 8'hFF, 8'h00, 1, 3);
    op("cmp_eq",       1, 8, 8'h3C, 8'h3C, 0, 3);
    op("cmp_gt",       1, 8, 8'h40, 8'h3C, 0, 3);
    op("cmp_lt",       1, 8, 8'h10, 8'h3C, 0, 3);
    op("rol",          0, 12, 8'h81, 8'h01, 0, 3);
    op("ror_bad_amt",  0, 13, 8'h01, 8'h11, 0, 3);
    op("ror",          0, 13, 8'h01, 8'h03, 0, 3);
    op("add_missing_b", 1, 0, 8'h12, 8'h34, 0, 1);
    op("inc_a_only_a", 1, 4, 8'h7F, 8'h00, 0, 1);
    op("dec_a_zero",   1, 5, 8'h00, 8'h00, 0, 1);
    op("dec_b_no_b",   1, 7, 8'h00, 8'h05, 0, 1);
    op("shl_b",        0, 11, 8'h00, 8'hC3, 0, 2);
    op("nand",         0, 1, 8'hF0, 8'h3C, 0, 3);
    for (int i = 0; i < 3; i++) idle_cycle("ce_hold");
    op("arith_bad_cmd", 1, 12, 8'h01, 8'h02, 0, 3);
    op("logic_bad_cmd", 0, 15, 8'h01, 8'h02, 0, 3);

    for (int i = 0; i < 300; i++) begin
      md   = $urandom_range(0, 1);
      cmd  = $urandom_range(0, 15);
      a    = $urandom_range(0, 255);
      b    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
      cin  = $urandom_range(0, 1);
      iv   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 3;
      ce_v = ($urandom_range(0, 4) != 0);
      drive(md, cmd, a, b, cin, iv, ce_v);
      @(posedge clk);
      #1;
      if (ce_v) expv = model(md, cmd, a, b, cin, iv);
      check("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
